mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Memory-mapped I/O responder: answers CPU loads and stores that target the I/O region.
- The stage-3 control path steers data-memory (0x0…) and BIOS memory (0x4…) accesses; this block serves the 0x8… region.
- Provides UART status, RX pop, TX push, cycle counter, retired-instruction counter and counter reset.
- Read data is registered, so it returns on the same timing as synchronous memory reads.

Parameters:
- MMIO_TAG, 4'h8, value of addr[31:28] that selects this block.
- CNT_W, 32, width of both counters; must be ≤ 32.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset, synchronous, active-high.
- addr  input  32  byte address from the execute-stage ALU.
- wdata  input  32  store data.
- re  input  1  load issued this cycle.
- we  input  1  store issued this cycle; only the full-word effect is used.
- instr_retire  input  1  one instruction retired this cycle.
- rdata  output  32  registered load data; valid the cycle after re.
- hit  output  1  combinational: addr[31:28]==MMIO_TAG.
- rx_data  input  8  UART receiver byte.
- rx_valid  input  1  receiver holds a byte.
- rx_ready  output  1  pop strobe to the receiver.
- tx_data  output  8  byte to the UART transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts the byte.

Behaviour:
- Register map, offset = addr[7:0], decoded only when hit=1:
  - 0x00 R: {30'b0, rx_valid, tx_ready_eff}, where tx_ready_eff = tx_ready & ~tx_valid.
  - 0x04 R: {24'b0, rx_data}; pops the byte.
  - 0x08 W: wdata[7:0] pushed to the transmitter.
  - 0x10 R: cycle_cnt.
  - 0x14 R: instr_cnt.
  - 0x18 W: clears both counters.
  - Any other offset reads 0; writes to it are ignored.
  - Reads of W-only offsets return 0; writes to R-only offsets are ignored.
- Load latency: re & hit at cycle N → rdata valid at N+1. rdata holds its value until the next re & hit. rdata is 0 after reset.
- RX pop: rx_ready = re & hit & (offset==0x04), combinational, one cycle wide. The transfer occurs only when rx_valid=1. rx_data is sampled into rdata at the same edge. A pop with rx_valid=0 returns {24'b0, rx_data} and removes nothing.
- TX FSM, states IDLE and PEND:
  - IDLE: we & hit & offset 0x08 → latch wdata[7:0] into tx_data, assert tx_valid, go to PEND.
  - PEND: tx_valid=1 and tx_data stays stable. On tx_valid & tx_ready → deassert tx_valid, return to IDLE.
  - A store to 0x08 while in PEND is dropped; software must poll 0x00 bit 0.
  - A push in the same cycle as the completing handshake is also dropped.
- Counters:
  - cycle_cnt increments every cycle.
  - instr_cnt increments when instr_retire=1.
  - Both wrap modulo 2^CNT_W.
  - Store to 0x18 → both counters read 0 after the next edge; increments that cycle are discarded and counting resumes from 0.
  - A load of 0x10/0x14 returns the pre-edge value of cycle N.
- re and we in the same cycle: both are honoured independently.
- Reset: rdata=0, tx_valid=0, tx_data=0, state IDLE, cycle_cnt=0, instr_cnt=0. rx_ready is combinational and is 0 whenever re=0.
- Reset mid-PEND drops the byte; tx_valid=0 the cycle after rst.
- hit=0: no side effects, and rdata keeps its old value.

Test Plan:
- Reset, then load 0x80000010 at cycle 5 after rst release → rdata at cycle 6 equals 5; load 0x80000014 with instr_retire never asserted → 0.
- Store 0x41 to 0x80000008 with tx_ready=0 for 3 cycles, then 1:
  - tx_valid high for 4 cycles with tx_data=0x41.
  - Status bit 0 reads 0 meanwhile and 1 after completion.
  - A second store 0x42 during PEND is never transmitted.
- rx_valid=1, rx_data=0x5A; load 0x80000000 → rdata=0x3 (tx idle, ready); load 0x80000004 → rx_ready pulses one cycle, rdata=0x5A.
- Counters near wrap (force cycle_cnt=0xFFFFFFFE) → reads 0xFFFFFFFF, then 0x00000000. Store to 0x80000018 with instr_retire=1 → both counters read 0, then instr_cnt counts from 0.
- Load 0x10000010 (hit=0) → rdata unchanged, rx_ready=0. Store to 0x80000020 → no state change.
- Assert rst during PEND → tx_valid=0 and both counters=0 the next cycle.

Source files
------------

// File: rtl/mmio_responder_if.sv
// CPU-side MMIO bus plus UART byte handshakes served by mmio_responder.
interface mmio_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic        instr_retire;
  logic [31:0] rdata;
  logic        hit;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output addr, wdata, re, we, instr_retire, rx_data, rx_valid, tx_ready,
    input  rdata, hit, rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  addr, wdata, re, we, instr_retire, rx_data, rx_valid, tx_ready,
    output rdata, hit, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_responder.sv
// I/O-region responder: UART status/RX/TX registers, cycle and retired-instruction
// counters, with registered read data matching synchronous memory timing.
module mmio_responder #(
  parameter logic [3:0]  MMIO_TAG = 4'h8,
  parameter int unsigned CNT_W    = 32
) (
  input logic            clk,
  input logic            rst,
  mmio_responder_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 8;

  localparam logic [OFF_W-1:0] OFF_STATUS = 8'h00;
  localparam logic [OFF_W-1:0] OFF_RX     = 8'h04;
  localparam logic [OFF_W-1:0] OFF_TX     = 8'h08;
  localparam logic [OFF_W-1:0] OFF_CYCLE  = 8'h10;
  localparam logic [OFF_W-1:0] OFF_INSTR  = 8'h14;
  localparam logic [OFF_W-1:0] OFF_CLR    = 8'h18;

  typedef enum logic {IDLE, PEND} tx_state_e;

  logic [OFF_W-1:0]  offset;
  logic              hit_c;
  logic              rd_en;
  logic              wr_en;
  logic              cnt_clr;
  logic              tx_push;
  logic              tx_ready_eff;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  instr_cnt;

  tx_state_e         state_q, state_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;

  logic              unused_bits;

  assign offset       = bus.addr[OFF_W-1:0];
  assign hit_c        = (bus.addr[31:28] == MMIO_TAG);
  assign rd_en        = bus.re & hit_c;
  assign wr_en        = bus.we & hit_c;
  assign cnt_clr      = wr_en & (offset == OFF_CLR);
  assign tx_push      = wr_en & (offset == OFF_TX);
  assign tx_ready_eff = bus.tx_ready & ~tx_valid_q;

  assign bus.hit      = hit_c;
  assign bus.rx_ready = rd_en & (offset == OFF_RX);
  assign bus.rdata    = rdata_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

  // Only the tag nibble, the offset byte and the low store byte matter here.
  assign unused_bits = ^{bus.addr[27:OFF_W], bus.wdata[DATA_W-1:8]};

  // Read decode; write-only and unmapped offsets read as zero.
  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_STATUS: rd_mux = {30'b0, bus.rx_valid, tx_ready_eff};
      OFF_RX:     rd_mux = {24'b0, bus.rx_data};
      OFF_CYCLE:  rd_mux = DATA_W'(cycle_cnt);
      OFF_INSTR:  rd_mux = DATA_W'(instr_cnt);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= rd_mux;
    end
  end

  // A clear wins over that cycle's increments so counting restarts at zero.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (bus.instr_retire) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // TX holds one byte; pushes while a byte is pending are dropped.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      IDLE: begin
        if (tx_push) begin
          tx_data_d  = bus.wdata[7:0];
          tx_valid_d = 1'b1;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: loads feed an expected-rdata queue that a
// negedge monitor drains; TX/RX strobes and reset values are checked inline.
module tb_mmio_responder;

  logic clk;
  logic rst;

  mmio_responder_if bus_m();
  mmio_responder_if bus_n();

  mmio_responder #(.MMIO_TAG(4'h8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus_m)
  );

  // Narrow counters so wrap-around is reachable in a short run.
  mmio_responder #(.MMIO_TAG(4'h8), .CNT_W(8)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_m[$];
  logic [31:0] q_n[$];
  logic        pend_m;
  logic        pend_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Loads that hit the I/O region owe a registered response one edge later.
  always @(posedge clk) begin
    pend_m <= !rst && bus_m.re && (bus_m.addr[31:28] == 4'h8);
    pend_n <= !rst && bus_n.re && (bus_n.addr[31:28] == 4'h8);
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (pend_m) begin
      if (q_m.size() == 0) chk("rdata_m_unexpected", bus_m.rdata, 32'hDEAD_BEEF);
      else begin e = q_m.pop_front(); chk("rdata_m", bus_m.rdata, e); end
    end
    if (pend_n) begin
      if (q_n.size() == 0) chk("rdata_n_unexpected", bus_n.rdata, 32'hDEAD_BEEF);
      else begin e = q_n.pop_front(); chk("rdata_n", bus_n.rdata, e); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_m(input logic [31:0] a, input logic [31:0] exp);
    bus_m.addr = a;
    bus_m.re   = 1'b1;
    if (a[31:28] == 4'h8) q_m.push_back(exp);
    tick();
    bus_m.re = 1'b0;
  endtask

  task automatic store_m(input logic [31:0] a, input logic [31:0] d);
    bus_m.addr  = a;
    bus_m.wdata = d;
    bus_m.we    = 1'b1;
    tick();
    bus_m.we = 1'b0;
  endtask

  task automatic load_n(input logic [31:0] a, input logic [31:0] exp);
    bus_n.addr = a;
    bus_n.re   = 1'b1;
    q_n.push_back(exp);
    tick();
    bus_n.re = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_m.addr = '0; bus_m.wdata = '0; bus_m.re = 0; bus_m.we = 0;
    bus_m.instr_retire = 0; bus_m.rx_data = '0; bus_m.rx_valid = 0; bus_m.tx_ready = 0;
    bus_n.addr = '0; bus_n.wdata = '0; bus_n.re = 0; bus_n.we = 0;
    bus_n.instr_retire = 0; bus_n.rx_data = '0; bus_n.rx_valid = 0; bus_n.tx_ready = 0;

    // Reset values
    repeat (3) tick();
    chk("rst_rdata", bus_m.rdata, 32'h0);
    chk("rst_tx_valid", 32'(bus_m.tx_valid), 32'h0);
    chk("rst_tx_data", 32'(bus_m.tx_data), 32'h0);
    chk("rst_rx_ready", 32'(bus_m.rx_ready), 32'h0);

    // Cycle counter read five cycles after release; instr counter untouched
    rst = 1'b0;
    repeat (5) tick();
    load_m(32'h8000_0010, 32'd5);
    load_m(32'h8000_0014, 32'd0);

    // Retire counting, then clear with a retire in the same cycle
    bus_m.instr_retire = 1'b1;
    repeat (3) tick();
    bus_m.instr_retire = 1'b0;
    load_m(32'h8000_0014, 32'd3);
    bus_m.instr_retire = 1'b1;
    store_m(32'h8000_0018, 32'h0);
    load_m(32'h8000_0014, 32'd0);
    load_m(32'h8000_0014, 32'd1);
    bus_m.instr_retire = 1'b0;
    load_m(32'h8000_0010, 32'd2);

    // Counter wrap on the narrow instance
    bus_n.addr = 32'h8000_0018; bus_n.we = 1'b1;
    tick();
    bus_n.we = 1'b0;
    repeat (255) tick();
    load_n(32'h8000_0010, 32'h0000_00FF);
    load_n(32'h8000_0010, 32'h0000_0000);

    // TX push with a stalled transmitter; second push during PEND is dropped
    bus_m.tx_ready = 1'b0;
    store_m(32'h8000_0008, 32'h0000_0041);
    chk("tx_valid_c1", 32'(bus_m.tx_valid), 32'h1);
    chk("tx_data_c1", 32'(bus_m.tx_data), 32'h41);
    store_m(32'h8000_0008, 32'h0000_0042);
    chk("tx_valid_c2", 32'(bus_m.tx_valid), 32'h1);
    chk("tx_data_c2", 32'(bus_m.tx_data), 32'h41);
    load_m(32'h8000_0000, 32'h0);
    chk("tx_valid_c3", 32'(bus_m.tx_valid), 32'h1);
    tick();
    chk("tx_valid_c4", 32'(bus_m.tx_valid), 32'h1);
    chk("tx_data_c4", 32'(bus_m.tx_data), 32'h41);
    bus_m.tx_ready = 1'b1;
    store_m(32'h8000_0008, 32'h0000_0042);
    chk("tx_done_valid", 32'(bus_m.tx_valid), 32'h0);
    chk("tx_done_data", 32'(bus_m.tx_data), 32'h41);
    load_m(32'h8000_0000, 32'h1);
    chk("tx_no_repush", 32'(bus_m.tx_valid), 32'h0);

    // RX status and pop
    bus_m.rx_valid = 1'b1;
    bus_m.rx_data  = 8'h5A;
    load_m(32'h8000_0000, 32'h3);
    bus_m.addr = 32'h8000_0004;
    bus_m.re   = 1'b1;
    #1;
    chk("rx_ready_pulse", 32'(bus_m.rx_ready), 32'h1);
    q_m.push_back(32'h0000_005A);
    tick();
    bus_m.re = 1'b0;
    #1;
    chk("rx_ready_low", 32'(bus_m.rx_ready), 32'h0);

    // Outside the I/O region: no strobe, rdata holds
    bus_m.addr = 32'h1000_0004;
    bus_m.re   = 1'b1;
    #1;
    chk("miss_hit", 32'(bus_m.hit), 32'h0);
    chk("miss_rx_ready", 32'(bus_m.rx_ready), 32'h0);
    tick();
    bus_m.re = 1'b0;
    load_m(32'h1000_0010, 32'h0);
    chk("miss_rdata_hold", bus_m.rdata, 32'h0000_005A);

    // Unmapped and write-only offsets
    store_m(32'h8000_0020, 32'hFFFF_FFFF);
    chk("unmapped_store_tx", 32'(bus_m.tx_valid), 32'h0);
    load_m(32'h8000_0020, 32'h0);
    load_m(32'h8000_0008, 32'h0);

    // Reset while a byte is pending
    bus_m.tx_ready = 1'b0;
    store_m(32'h8000_0008, 32'h0000_0055);
    chk("pend_before_rst", 32'(bus_m.tx_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pend_tx_valid", 32'(bus_m.tx_valid), 32'h0);
    chk("rst_pend_rdata", bus_m.rdata, 32'h0);
    load_m(32'h8000_0010, 32'h0);
    load_m(32'h8000_0014, 32'h0);

    repeat (2) tick();
    chk("queue_m_drained", 32'(q_m.size()), 32'h0);
    chk("queue_n_drained", 32'(q_n.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
